mem_arbiter: RTL and testbench

Two-port arbiter sharing the single synchronous-read unified memory between the multicycle CPU datapath (port 0: instruction fetch and load/store) and a loader/debug master (port 1). Each cycle it forwards at most one access to the memory and routes read data back with one-cycle latency. It is round-robin with a bounded hold time, so neither master starves. It sits between the CPU's address mux/B register and the memory macro, and provides a stall indication to the CPU control FSM.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_port.sv | 34 +++
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared FSM state encodings and owner indices for the two-port memory arbiter.
// States are plain logic constants so the encoding stays visible to legacy tools.
package mem_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_OWN0 = 2'd1;
    localparam arb_state_t ST_OWN1 = 2'd2;

    localparam logic OWNER_P0 = 1'b0;
    localparam logic OWNER_P1 = 1'b1;

    function automatic arb_state_t own_state(input logic owner);
        return (owner == OWNER_P1) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/mem_arb_port.sv
// Per-port slice of the memory arbiter: grant gating, stall flag and the
// one-cycle read-valid register that qualifies the shared read data.
module mem_arb_port #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_own,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_gnt,
    output logic              o_stall,
    output logic              o_rvalid,
    output logic [DATA_W-1:0] o_rdata
);

    logic r_rvalid;

    assign o_gnt    = i_own & i_req;
    assign o_stall  = i_req & ~o_gnt;
    assign o_rvalid = r_rvalid;
    assign o_rdata  = i_mem_rdata;

    // Reset drops any read still in flight so no stale rvalid appears afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= o_gnt & ~i_we;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin, hold-bounded arbiter between the CPU (port 0) and a loader/debug
// master (port 1) in front of one synchronous-read memory. Define MEM_ARB_LOCK_EN
// to add the p1_lock burst-lock input.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_stall,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic              p1_lock,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_last;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_p1_stall;
    logic              w_p1_lock;
    logic              w_hold_expired;

`ifdef MEM_ARB_LOCK_EN
    assign w_p1_lock = p1_lock;
`else
    assign w_p1_lock = 1'b0;
`endif

    assign w_hold_expired = (r_hold_cnt == HOLD_LAST);

    mem_arb_port #(.DATA_W(DATA_W)) u_port0 (
        .clk         (clk),
        .rst         (rst),
        .i_own       (r_state == ST_OWN0),
        .i_req       (p0_req),
        .i_we        (p0_we),
        .i_mem_rdata (mem_rdata),
        .o_gnt       (p0_gnt),
        .o_stall     (p0_stall),
        .o_rvalid    (p0_rvalid),
        .o_rdata     (p0_rdata)
    );

    mem_arb_port #(.DATA_W(DATA_W)) u_port1 (
        .clk         (clk),
        .rst         (rst),
        .i_own       (r_state == ST_OWN1),
        .i_req       (p1_req),
        .i_we        (p1_we),
        .i_mem_rdata (mem_rdata),
        .o_gnt       (p1_gnt),
        .o_stall     (w_p1_stall),
        .o_rvalid    (p1_rvalid),
        .o_rdata     (p1_rdata)
    );

    // While one port owns the memory, the other's stall flag is exactly "it is waiting".
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (p0_req && p1_req) begin
                    w_state_next = own_state(~r_last);
                end else if (p0_req) begin
                    w_state_next = ST_OWN0;
                end else if (p1_req) begin
                    w_state_next = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!p0_req) begin
                    w_state_next = p1_req ? ST_OWN1 : ST_IDLE;
                end else if (w_p1_stall && w_hold_expired) begin
                    w_state_next = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (w_p1_lock) begin
                    w_state_next = ST_OWN1;
                end else if (!p1_req) begin
                    w_state_next = p0_req ? ST_OWN0 : ST_IDLE;
                end else if (p0_stall && w_hold_expired) begin
                    w_state_next = ST_OWN0;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // hold_cnt restarts on every ownership change and saturates once the window is used up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last     <= OWNER_P1;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_hold_cnt <= '0;
                if (w_state_next != ST_IDLE) begin
                    r_last <= (w_state_next == ST_OWN1) ? OWNER_P1 : OWNER_P0;
                end
            end else if ((p0_gnt || p1_gnt) && !w_hold_expired) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_OWN0: begin
                mem_en    = p0_req;
                mem_we    = p0_we;
                mem_addr  = p0_addr;
                mem_wdata = p0_wdata;
            end
            ST_OWN1: begin
                mem_en    = p1_req;
                mem_we    = p1_we;
                mem_addr  = p1_addr;
                mem_wdata = p1_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small synchronous-read memory model.
// Inputs are driven on the falling edge and outputs sampled 1ns later.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_we, p1_req, p1_we;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_gnt, p0_rvalid, p0_stall, p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef MEM_ARB_LOCK_EN
    logic              p1_lock;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] memArray   [256];
    logic              memWritten [256] = '{default: 1'b0};

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_stall  (p0_stall),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
`ifdef MEM_ARB_LOCK_EN
        .p1_lock   (p1_lock),
`endif
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DATA_W-1:0] preload(input logic [ADDR_W-1:0] a);
        case (a)
            8'h10:   return 32'h2402_0005;
            8'h11:   return 32'h1234_5678;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Memory model: contents not yet written come from the preload table.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                memArray[mem_addr]   <= mem_wdata;
                memWritten[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= memWritten[mem_addr] ? memArray[mem_addr] : preload(mem_addr);
            end
        end
    end

    task automatic clearInputs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        p1_lock = 1'b0;
`endif
    endtask

    // Leaves the bench at a falling edge with reset released; the caller drives cycle 0.
    task automatic doReset();
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        p0_req = 1'b1; p1_req = 1'b1;
        #1;
        checks++; if (p0_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_p0_gnt: got %0b expected 0", p0_gnt); end
        checks++; if (p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_p1_gnt: got %0b expected 0", p1_gnt); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_en: got %0b expected 0", mem_en); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_p0_rvalid: got %0b expected 0", p0_rvalid); end
        checks++; if (p1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_p1_rvalid: got %0b expected 0", p1_rvalid); end
        checks++; if (p0_stall !== 1'b1) begin errors++; $display("[TB] FAIL reset_stall_follows_req: got %0b expected 1", p0_stall); end
        p0_req = 1'b0;
        #1;
        checks++; if (p0_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_idle: got %0b expected 0", p0_stall); end
    endtask

    task automatic test_read();
        doReset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
        #1;
        checks++; if (p0_gnt !== 1'b0) begin errors++; $display("[TB] FAIL read_c0_gnt: got %0b expected 0", p0_gnt); end
        @(negedge clk); #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL read_c1_gnt: got %0b expected 1", p0_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_addr !== 8'h10) begin errors++; $display("[TB] FAIL read_c1_mem: got en=%0b addr=%0h expected en=1 addr=10", mem_en, mem_addr); end
        @(negedge clk);
        p0_req = 1'b0;
        #1;
        checks++; if (p0_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL read_c2_rvalid: got %0b expected 1", p0_rvalid); end
        checks++; if (p0_rdata !== 32'h2402_0005) begin errors++; $display("[TB] FAIL read_c2_rdata: got %0h expected 24020005", p0_rdata); end
        checks++; if (p1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL read_c2_p1_rvalid: got %0b expected 0", p1_rvalid); end
        @(negedge clk); #1;
        checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL read_c3_rvalid: got %0b expected 0", p0_rvalid); end
    endtask

    task automatic test_back_to_back();
        doReset();
        p0_req = 1'b1; p0_addr = 8'h10;
        @(negedge clk); #1;
        checks++; if (p0_gnt !== 1'b1 || mem_addr !== 8'h10) begin errors++; $display("[TB] FAIL b2b_first: got gnt=%0b addr=%0h expected gnt=1 addr=10", p0_gnt, mem_addr); end
        @(negedge clk);
        p0_addr = 8'h11;
        #1;
        checks++; if (p0_gnt !== 1'b1 || mem_addr !== 8'h11) begin errors++; $display("[TB] FAIL b2b_second: got gnt=%0b addr=%0h expected gnt=1 addr=11", p0_gnt, mem_addr); end
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h2402_0005) begin errors++; $display("[TB] FAIL b2b_data0: got v=%0b d=%0h expected v=1 d=24020005", p0_rvalid, p0_rdata); end
        @(negedge clk);
        p0_req = 1'b0;
        #1;
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL b2b_data1: got v=%0b d=%0h expected v=1 d=12345678", p0_rvalid, p0_rdata); end
    endtask

    task automatic test_tie_handover();
        doReset();
        p0_req = 1'b1; p0_addr = 8'h01;
        p1_req = 1'b1; p1_addr = 8'h02;
        #1;
        checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL tie_c0: got g0=%0b g1=%0b expected 0 0", p0_gnt, p1_gnt); end
        @(negedge clk); #1;
        checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL tie_c1_p0_first: got g0=%0b g1=%0b expected 1 0", p0_gnt, p1_gnt); end
        checks++; if (mem_addr !== 8'h01) begin errors++; $display("[TB] FAIL tie_c1_addr: got %0h expected 01", mem_addr); end
        @(negedge clk);
        p0_req = 1'b0;
        #1;
        checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL tie_c2_release: got g0=%0b g1=%0b expected 0 0", p0_gnt, p1_gnt); end
        checks++; if (p0_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL tie_c2_rvalid: got %0b expected 1", p0_rvalid); end
        @(negedge clk); #1;
        checks++; if (p1_gnt !== 1'b1 || mem_addr !== 8'h02) begin errors++; $display("[TB] FAIL tie_c3_handover: got g1=%0b addr=%0h expected g1=1 addr=02", p1_gnt, mem_addr); end
        @(negedge clk);
        p1_req = 1'b0;
        #1;
        checks++; if (p1_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL tie_c4_p1_rvalid: got %0b expected 1", p1_rvalid); end
    endtask

    task automatic test_hold_rotation();
        logic expP0;
        logic prevP0;
        doReset();
        p0_req = 1'b1; p0_addr = 8'h10;
        p1_req = 1'b1; p1_addr = 8'h11;
        #1;
        checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rot_c0: got g0=%0b g1=%0b expected 0 0", p0_gnt, p1_gnt); end
        prevP0 = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk); #1;
            expP0 = (i <= 4) || (i >= 9);
            checks++; if (p0_gnt !== expP0 || p1_gnt !== !expP0) begin errors++; $display("[TB] FAIL rot_gnt_c%0d: got g0=%0b g1=%0b expected g0=%0b g1=%0b", i, p0_gnt, p1_gnt, expP0, !expP0); end
            checks++; if (p0_stall !== !expP0) begin errors++; $display("[TB] FAIL rot_stall_c%0d: got %0b expected %0b", i, p0_stall, !expP0); end
            checks++; if (p0_rvalid !== prevP0) begin errors++; $display("[TB] FAIL rot_rvalid_c%0d: got %0b expected %0b", i, p0_rvalid, prevP0); end
            prevP0 = expP0;
        end
        @(negedge clk);
        p0_req = 1'b0; p1_req = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL rot_drop_mem_en: got %0b expected 0", mem_en); end
        @(negedge clk);
        p1_req = 1'b1;
        #1;
        checks++; if (p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rot_idle_after_drop: got %0b expected 0", p1_gnt); end
        @(negedge clk); #1;
        checks++; if (p1_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rot_regrant: got %0b expected 1", p1_gnt); end
        @(negedge clk);
        clearInputs();
    endtask

    task automatic test_write_read();
        doReset();
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h20; p1_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL wr_c0_gnt: got %0b expected 0", p1_gnt); end
        @(negedge clk); #1;
        checks++; if (p1_gnt !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_c1_gnt_we: got g1=%0b we=%0b expected 1 1", p1_gnt, mem_we); end
        checks++; if (mem_addr !== 8'h20 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wr_c1_bus: got addr=%0h data=%0h expected 20 deadbeef", mem_addr, mem_wdata); end
        @(negedge clk);
        p1_req = 1'b0; p1_we = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h20;
        #1;
        checks++; if (p1_rvalid !== 1'b0 || p0_gnt !== 1'b0) begin errors++; $display("[TB] FAIL wr_c2: got p1_rvalid=%0b g0=%0b expected 0 0", p1_rvalid, p0_gnt); end
        @(negedge clk); #1;
        checks++; if (p0_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h20) begin errors++; $display("[TB] FAIL wr_c3_read: got g0=%0b we=%0b addr=%0h expected 1 0 20", p0_gnt, mem_we, mem_addr); end
        checks++; if (p1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_c3_p1_rvalid: got %0b expected 0", p1_rvalid); end
        @(negedge clk);
        p0_req = 1'b0;
        #1;
        checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wr_c4_rdata: got v=%0b d=%0h expected v=1 d=deadbeef", p0_rvalid, p0_rdata); end
        checks++; if (p1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_c4_p1_rvalid: got %0b expected 0", p1_rvalid); end
    endtask

    task automatic test_reset_outstanding();
        doReset();
        p0_req = 1'b1; p0_addr = 8'h10;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rstout_c1_gnt: got %0b expected 1", p0_gnt); end
        @(negedge clk);
        rst = 1'b0; p0_req = 1'b0;
        #1;
        checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstout_c2_rvalid: got r0=%0b r1=%0b expected 0 0", p0_rvalid, p1_rvalid); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("[TB] FAIL rstout_c2_mem_en: got %0b expected 0", mem_en); end
        @(negedge clk);
        p0_req = 1'b1;
        #1;
        checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstout_c3_late_rvalid: got %0b expected 0", p0_rvalid); end
        checks++; if (p0_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rstout_c3_idle: got %0b expected 0", p0_gnt); end
        @(negedge clk);
        clearInputs();
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        int p1Grants;
        logic expG1;
        doReset();
        p1_lock = 1'b1; p1_req = 1'b1; p1_addr = 8'h30;
        #1;
        checks++; if (p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL lock_c0: got %0b expected 0", p1_gnt); end
        p1Grants = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            p0_req = 1'b1;
            p1_req = (i != 4);
            #1;
            expG1 = (i != 4);
            if (p1_gnt === 1'b1) p1Grants++;
            checks++; if (p1_gnt !== expG1 || p0_gnt !== 1'b0) begin errors++; $display("[TB] FAIL lock_c%0d: got g0=%0b g1=%0b expected g0=0 g1=%0b", i, p0_gnt, p1_gnt, expG1); end
        end
        checks++; if (p1Grants != 6) begin errors++; $display("[TB] FAIL lock_grant_count: got %0d expected 6", p1Grants); end
        @(negedge clk);
        p1_req = 1'b0; p1_lock = 1'b0;
        #1;
        checks++; if (p0_gnt !== 1'b0) begin errors++; $display("[TB] FAIL lock_release: got %0b expected 0", p0_gnt); end
        @(negedge clk); #1;
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL lock_p0_after: got %0b expected 1", p0_gnt); end
        @(negedge clk);
        clearInputs();
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        rst = 1'b1;
        $display("[TB] mem_arbiter directed test start");
        test_reset();
        test_read();
        test_back_to_back();
        test_tie_handover();
        test_hold_rotation();
        test_write_read();
        test_reset_outstanding();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
